sw_debounce: RTL

- Front-end conditioning stage for the board slide switches.
- Synchronises and debounces the raw switch pins, then feeds clean levels to the downstream switch-driven logic (mux select and data buses).
- Also emits one-cycle rise/fall event pulses per switch for later event-driven blocks.
- One instance sits in the board top, between the raw switch pins and the packed buses.

---
 rtl/sw_debounce.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Front-end conditioning for the board slide switches. Each raw pin passes
//   through a two-flop synchroniser and then a per-channel debounce FSM.
//   A channel's debounced level flips only after the synchronised input has
//   differed from it for STABLE_CYCLES consecutive cycles. One-cycle rise/fall
//   event pulses are emitted on every committed flip.
//
// Parameters
//   N_SW           number of independent switch channels
//   STABLE_CYCLES  consecutive mismatching cycles needed to commit (>= 1)
//   CNT_W          per-channel counter width, 2**CNT_W > STABLE_CYCLES-1
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   sw_raw      raw switch pins, asynchronous to clk
//   sw_db       debounced switch levels (registered)
//   sw_rise     one-cycle pulse per bit on a debounced 0->1
//   sw_fall     one-cycle pulse per bit on a debounced 1->0
//   sw_any_chg  one-cycle pulse when any bit rises or falls
//   evt_cnt     (only with SW_DEBOUNCE_EVENT_CNT_EN) 8-bit wrapping count of
//               committed rises on bit 0
//
// Build option
//   SW_DEBOUNCE_EVENT_CNT_EN  adds the evt_cnt port and its counter.
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int N_SW          = 10,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_any_chg
`ifdef SW_DEBOUNCE_EVENT_CNT_EN
  ,
  output logic [7:0]      evt_cnt
`endif
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_SW-1:0]  s1;
  logic [N_SW-1:0]  s2;
  state_e           state_q [N_SW];
  state_e           state_d [N_SW];
  logic [CNT_W-1:0] cnt_q   [N_SW];
  logic [CNT_W-1:0] cnt_d   [N_SW];
  logic [N_SW-1:0]  db_d;
  logic [N_SW-1:0]  rise_d;
  logic [N_SW-1:0]  fall_d;

  // Two-flop synchroniser; only s2 is used downstream.
  // NOTE: sequential state uses non-blocking assignments so that s2 takes the
  // old s1 value, not the value written earlier in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Next-state logic for all channels. In ST_STABLE the counter is always 0,
  // so a single-cycle debounce (STABLE_CYCLES == 1) commits straight away.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise paths
    // that do not assign it would infer latches.
    db_d   = sw_db;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_SW; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_STABLE: begin
          if (s2[i] != sw_db[i]) begin
            if (STABLE_CYCLES == 1) begin
              db_d[i]   = s2[i];
              rise_d[i] = s2[i];
              fall_d[i] = ~s2[i];
            end else begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        ST_PENDING: begin
          if (s2[i] == sw_db[i]) begin
            // Glitch rejected: input came back before the count completed.
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
            db_d[i]    = s2[i];
            rise_d[i]  = s2[i];
            fall_d[i]  = ~s2[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Per-channel state and counters.
  // NOTE: the counter array is reset explicitly, element by element; a reset
  // mid-count must discard the pending change, so it cannot be left to power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Registered outputs. sw_any_chg is taken from the same next-values so it
  // lines up with the rise/fall pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_db      <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_any_chg <= 1'b0;
    end else begin
      sw_db      <= db_d;
      sw_rise    <= rise_d;
      sw_fall    <= fall_d;
      sw_any_chg <= |(rise_d | fall_d);
    end
  end

`ifdef SW_DEBOUNCE_EVENT_CNT_EN
  // Press counter for bit 0; wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
    end else begin
      evt_cnt <= evt_cnt + {7'd0, rise_d[0]};
    end
  end
`endif

endmodule
